// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: register index width, stage indices and the
// default stage at which load data first appears on the result bus.
package cpu_pkg;

    localparam int REG_ADDR_W           = 4;
    localparam int STG_EX               = 0;
    localparam int STG_ME               = 1;
    localparam int DEF_LOAD_READY_STAGE = STG_ME;

endpackage

// File: rtl/fwd_port_select.sv
// Per-read-port bypass selection: finds the youngest in-flight producer of the
// requested register and reports whether its result can be forwarded yet.
module fwd_port_select
    import cpu_pkg::*;
#(
    parameter int DATA_W           = 16,
    parameter int ADDR_W           = REG_ADDR_W,
    parameter int STAGES           = 2,
    parameter int LOAD_READY_STAGE = DEF_LOAD_READY_STAGE
) (
    input  logic [STAGES-1:0]        tagValid,
    input  logic [STAGES*ADDR_W-1:0] tagAddr,
    input  logic [STAGES-1:0]        tagLoad,
    input  logic [ADDR_W-1:0]        rdAddr,
    input  logic [DATA_W-1:0]        rfData,
    input  logic [STAGES*DATA_W-1:0] stageResult,
    output logic                     hit,
    output logic                     ready,
    output logic [DATA_W-1:0]        data
);

    // The first match in stage order is the youngest producer; once found,
    // older matches are ignored even when the young one cannot forward yet.
    always_comb begin
        logic found;
        found = 1'b0;
        hit   = 1'b0;
        ready = 1'b1;
        data  = rfData;
        for (int k = 0; k < STAGES; k++) begin
            if (!found && tagValid[k] && (tagAddr[k*ADDR_W +: ADDR_W] == rdAddr)) begin
                found = 1'b1;
                if (tagLoad[k] && (k < LOAD_READY_STAGE)) begin
                    ready = 1'b0;
                end else begin
                    hit  = 1'b1;
                    data = stageResult[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks destination tags through the
// post-decode stages, bypasses operands per read port and stalls on load-use.
module fwd_hazard_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W           = 16,
    parameter int ADDR_W           = REG_ADDR_W,
    parameter int STAGES           = 2,
    parameter int READ_PORTS       = 2,
    parameter int LOAD_READY_STAGE = DEF_LOAD_READY_STAGE,
    parameter int CNT_W            = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic                         id_wr_en,
    input  logic [ADDR_W-1:0]            id_wr_addr,
    input  logic                         id_is_load,
    input  logic [READ_PORTS*ADDR_W-1:0] id_rd_addr,
    input  logic [READ_PORTS-1:0]        id_rd_used,
    input  logic                         flush,
    input  logic [READ_PORTS*DATA_W-1:0] rf_data,
    input  logic [STAGES*DATA_W-1:0]     stage_result,
    output logic [READ_PORTS*DATA_W-1:0] fwd_data,
    output logic [READ_PORTS-1:0]        fwd_hit,
    output logic                         stall,
    output logic [CNT_W-1:0]             stall_count
);

    logic [STAGES-1:0]        tagValid;
    logic [STAGES*ADDR_W-1:0] tagAddr;
    logic [STAGES-1:0]        tagLoad;
    logic [READ_PORTS-1:0]    portReady;
    logic [READ_PORTS-1:0]    blocked;
    logic                     newValid;

    genvar p;
    generate
        for (p = 0; p < READ_PORTS; p++) begin : gPort
            fwd_port_select #(
                .DATA_W           (DATA_W),
                .ADDR_W           (ADDR_W),
                .STAGES           (STAGES),
                .LOAD_READY_STAGE (LOAD_READY_STAGE)
            ) uSelect (
                .tagValid    (tagValid),
                .tagAddr     (tagAddr),
                .tagLoad     (tagLoad),
                .rdAddr      (id_rd_addr[p*ADDR_W +: ADDR_W]),
                .rfData      (rf_data[p*DATA_W +: DATA_W]),
                .stageResult (stage_result),
                .hit         (fwd_hit[p]),
                .ready       (portReady[p]),
                .data        (fwd_data[p*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Tags clear asynchronously, so stall and hits drop the instant rst rises.
    assign blocked  = id_rd_used & ~portReady;
    assign stall    = id_valid & ~flush & (|blocked);
    assign newValid = id_valid & id_wr_en & ~flush & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagValid <= '0;
            tagAddr  <= '0;
            tagLoad  <= '0;
        end else begin
            tagValid[STG_EX]         <= newValid;
            tagAddr[0 +: ADDR_W]     <= id_wr_addr;
            tagLoad[STG_EX]          <= id_is_load;
            for (int k = STG_ME; k < STAGES; k++) begin
                tagValid[k]                 <= tagValid[k-1];
                tagAddr[k*ADDR_W +: ADDR_W] <= tagAddr[(k-1)*ADDR_W +: ADDR_W];
                tagLoad[k]                  <= tagLoad[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the fixed two-stage, two-port bypass network in the pipelined CPU.
- Tracks in-flight destination registers through a configurable number of post-decode stages.
- Selects, per configurable read port, the youngest valid forwarding source.
- Detects load-use hazards and raises a stall that inserts a bubble.
- Sits between instruction decode, the register file read ports and the EX/ME result buses; also exports a stall counter for the VGA debug path.

Parameters:
- DATA_W, 16, datapath width.
- ADDR_W, 4, register index width.
- STAGES, 2, number of tracked post-decode stages (stage 0 = EX, youngest).
- READ_PORTS, 2, number of decode read ports.
- LOAD_READY_STAGE, 1, first stage index at which a load result is valid on stage_result.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_wr_en  in  1  decoded instruction writes a register
- id_wr_addr  in  ADDR_W  decoded destination register
- id_is_load  in  1  decoded instruction is a memory load
- id_rd_addr  in  READ_PORTS*ADDR_W  source register per port (port p at bits p*ADDR_W)
- id_rd_used  in  READ_PORTS  port p actually consumes its operand
- flush  in  1  squash the decode-slot instruction
- rf_data  in  READ_PORTS*DATA_W  register file read data per port
- stage_result  in  STAGES*DATA_W  result bus at the end of each stage
- fwd_data  out  READ_PORTS*DATA_W  operand per port after bypass
- fwd_hit  out  READ_PORTS  port p is forwarded rather than read from the register file
- stall  out  1  hold IF/ID and insert a bubble into stage 0
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Tag pipeline: each stage k holds valid, addr and is_load; all are registers.
- Advance every cycle, no enable:
  - stage k+1 <= stage k.
  - stage 0 <= {id_valid & id_wr_en & !flush & !stall, id_wr_addr, id_is_load}.
  - On stall, stage 0 receives a bubble (valid=0) while older stages keep shifting.
- Match for port p at stage k: stage k valid & addr == id_rd_addr[p].
- Forwarding (combinational from tag registers and inputs):
  - The lowest k with a match wins, i.e. the youngest producer.
  - If the winning k is a load with k < LOAD_READY_STAGE, the port is not ready.
  - If ready: fwd_data[p] = stage_result[k] and fwd_hit[p] = 1.
  - With no match: fwd_data[p] = rf_data[p] and fwd_hit[p] = 0.
  - An older matching stage is never used when a younger match exists, even if the younger match is not ready.
- stall = OR over p of (id_valid & id_rd_used[p] & port p not ready). flush forces stall = 0.
- A load-use stall lasts exactly LOAD_READY_STAGE cycles, then clears on its own as the load advances.
- stall_count increments by 1 on each cycle with stall=1 and saturates at all-ones; it does not wrap.
- Reset (asynchronous): all stage valid bits = 0 and stall_count = 0. Consequently stall = 0, fwd_hit = 0 and fwd_data = rf_data from the moment of assertion. A reset mid-stall drops the stall immediately.
- No latency on forwarding paths; one cycle from decode to stage 0 tag visibility.
- Same-cycle write of a register being read by the decode slot is the register file's responsibility and is out of scope.

Decomposition:
- Shared package (cpu_pkg):
  - Register index width constant.
  - Stage index constants: STG_EX=0, STG_ME=1.
  - Default LOAD_READY_STAGE.
- Natural sub-module: fwd_port_select.
  - Per-port priority search over the STAGES tags.
  - Outputs hit, ready and selected data.
  - Instantiated READ_PORTS times via generate.

Test Plan:
- Reset mid-stall:
  - Stimulus: load R4 at cycle n, read R4 at n+1; assert rst during n+1.
  - Expected: stall drops to 0 asynchronously, fwd_data = rf_data, stall_count = 0.
- ALU back-to-back:
  - Stimulus: write R3 at n; at n+1 port0 reads R3 with stage_result[0]=0x1234.
  - Expected: fwd_hit[0]=1, fwd_data[0]=0x1234, stall=0.
- Distance-two:
  - Stimulus: write R5 at n, unrelated instruction at n+1, port1 reads R5 at n+2 with stage_result[1]=0x0F0F.
  - Expected: fwd_data[1]=0x0F0F.
- Youngest wins:
  - Stimulus: R2 in stage0 (0xAAAA) and stage1 (0x5555); both ports read R2.
  - Expected: both ports give 0xAAAA.
- Load-use:
  - Stimulus: load R4 at n, read R4 at n+1.
  - Expected: stall=1 for exactly one cycle and stage0 bubble. At n+2, fwd_data = stage_result[1] = 0xBEEF, stall=0, stall_count=1.
- Unused operand, flush and saturation (CNT_W=2):
  - id_rd_used=0 on a load match → stall=0.
  - flush during a load-use condition → stall=0.
  - 5 consecutive stall cycles → stall_count holds at 3.
